// File: rtl/usb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : usb_pkg
// Description : Shared constants and state encoding for the USB bit stuffer.
// Revision    : 1.0 - initial release
// ============================================================================
package usb_pkg;

    localparam int c_STUFF_LEN_DEFAULT = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        STUFF = 2'd2
    } bs_state_t;

endpackage : usb_pkg
`default_nettype wire

// File: rtl/bit_stuffer.sv
`default_nettype none
// ============================================================================
// Module      : bit_stuffer
// Description : Inserts a 0 after STUFF_LEN consecutive 1s in a ready/valid
//               serial bit stream, with a registered output stage.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_stuffer
    import usb_pkg::*;
#(
    parameter int STUFF_LEN = c_STUFF_LEN_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic in_bit,
    input  logic in_valid,
    output logic bs_ready,
    output logic out_bit,
    output logic out_valid,
    input  logic out_ready
);

    localparam int c_CNT_W = $clog2(STUFF_LEN + 1);

    bs_state_t          r_state;
    bs_state_t          w_next_state;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] w_cnt_inc;
    logic               r_out_bit;
    logic               r_out_valid;
    logic               w_bs_ready;
    logic               w_accept;
    logic               w_load_stuff;
    logic               w_hit_limit;

    always_comb begin
        w_bs_ready   = (r_state != STUFF) && (!r_out_valid || out_ready);
        w_accept     = in_valid && w_bs_ready;
        w_load_stuff = (r_state == STUFF) && (!r_out_valid || out_ready);
        w_cnt_inc    = r_count + c_CNT_W'(1);
        w_hit_limit  = in_bit && (w_cnt_inc == c_CNT_W'(STUFF_LEN));
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = w_hit_limit ? STUFF : XFER;
                end
            end
            XFER: begin
                if (w_accept) begin
                    w_next_state = w_hit_limit ? STUFF : XFER;
                end else if (w_bs_ready) begin
                    // Upstream gap while we could have accepted: packet over.
                    w_next_state = IDLE;
                end
            end
            STUFF: begin
                if (w_load_stuff) begin
                    w_next_state = XFER;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_out_bit   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_out_bit   <= in_bit;
                r_out_valid <= 1'b1;
                r_count     <= in_bit ? w_cnt_inc : '0;
            end else if (w_load_stuff) begin
                r_out_bit   <= 1'b0;
                r_out_valid <= 1'b1;
                r_count     <= '0;
            end else begin
                if (out_ready) begin
                    r_out_valid <= 1'b0;
                end
                if (w_next_state == IDLE) begin
                    r_count <= '0;
                end
            end
        end
    end

    assign bs_ready  = w_bs_ready;
    assign out_bit   = r_out_bit;
    assign out_valid = r_out_valid;

endmodule : bit_stuffer
`default_nettype wire

// File: tb/tb_bit_stuffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bit_stuffer
// Description : Directed, table-driven self-checking bench for bit_stuffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_stuffer;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic in_bit = 1'b0;
    logic in_valid = 1'b0;
    logic bs_ready;
    logic out_bit;
    logic out_valid;
    logic out_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    bit_stuffer #(.STUFF_LEN(6)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_bit   (in_bit),
        .in_valid (in_valid),
        .bs_ready (bs_ready),
        .out_bit  (out_bit),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clock = ~clock;

    // One row per cycle: inputs driven after negedge, outputs expected in that cycle.
    typedef struct {
        logic rst;
        logic ib;
        logic iv;
        logic ebs;
        logic eov;
        logic eob;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, input logic ib, input logic iv,
                                input logic ebs, input logic eov, input logic eob);
        vec_t v;
        v.rst = rst; v.ib = ib; v.iv = iv;
        v.ebs = ebs; v.eov = eov; v.eob = eob;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [13:0] exp_stream;
        logic        got[$];
        logic        act_ob;
        int          idx;
        int          nout;
        int          stalled;

        // Reset
        add(1,0,0, 1,0,0); add(1,0,0, 1,0,0); add(0,0,0, 1,0,0);
        // SYNC 0000_0001
        add(0,0,1, 1,0,0);
        for (int i = 0; i < 6; i++) add(0,0,1, 1,1,0);
        add(0,1,1, 1,1,0);
        add(0,0,0, 1,1,1);
        add(0,0,0, 1,0,0);
        // Eight 1s: one stall cycle after the sixth
        add(0,1,1, 1,0,0);
        for (int i = 0; i < 5; i++) add(0,1,1, 1,1,1);
        add(0,1,1, 0,1,1);
        add(0,1,1, 1,1,0);
        add(0,1,1, 1,1,1);
        add(0,0,0, 1,1,1);
        add(0,0,0, 1,0,0);
        // Packet ending in six 1s: stuffed 0 still emitted
        add(0,0,1, 1,0,0);
        add(0,1,1, 1,1,0);
        for (int i = 0; i < 5; i++) add(0,1,1, 1,1,1);
        add(0,0,0, 0,1,1);
        add(0,0,0, 1,1,0);
        add(0,0,0, 1,0,0);
        // Back-to-back packets 111 / 1111 must not share a count
        add(0,1,1, 1,0,0);
        for (int i = 0; i < 2; i++) add(0,1,1, 1,1,1);
        add(0,0,0, 1,1,1);
        add(0,1,1, 1,0,0);
        for (int i = 0; i < 3; i++) add(0,1,1, 1,1,1);
        add(0,0,0, 1,1,1);
        add(0,0,0, 1,0,0);
        // Reset while in STUFF, then a fresh packet of six 1s
        add(0,1,1, 1,0,0);
        for (int i = 0; i < 5; i++) add(0,1,1, 1,1,1);
        add(1,1,1, 1,0,0);
        add(1,0,0, 1,0,0);
        add(0,0,0, 1,0,0);
        add(0,0,0, 1,0,0);
        add(0,1,1, 1,0,0);
        for (int i = 0; i < 5; i++) add(0,1,1, 1,1,1);
        add(0,0,0, 0,1,1);
        add(0,0,0, 1,1,0);
        add(0,0,0, 1,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock);
            reset     = vecs[i].rst;
            in_bit    = vecs[i].ib;
            in_valid  = vecs[i].iv;
            out_ready = 1'b1;
            #1;
            act_ob = out_valid ? out_bit : 1'b0;
            checks++;
            if (bs_ready !== vecs[i].ebs || out_valid !== vecs[i].eov ||
                act_ob !== vecs[i].eob) begin
                errors++;
                $display("FAIL vec%0d: got bs_ready=%b out_valid=%b out_bit=%b, expected %b %b %b",
                         i, bs_ready, out_valid, act_ob,
                         vecs[i].ebs, vecs[i].eov, vecs[i].eob);
            end
        end

        // Twelve 1s with a 3-cycle downstream stall after the third output
        exp_stream = 14'b11111101111110;
        idx = 0; nout = 0; stalled = 0;
        for (int cyc = 0; cyc < 60 && nout < 14; cyc++) begin
            @(negedge clock);
            reset     = 1'b0;
            in_bit    = 1'b1;
            in_valid  = (idx < 12);
            out_ready = !(nout == 3 && stalled < 3);
            #1;
            if (!out_ready) begin
                checks++;
                if (bs_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_bs_ready: got %b, expected 0", bs_ready);
                end
                stalled++;
            end
            if (in_valid && bs_ready) idx++;
            if (out_valid && out_ready) begin
                got.push_back(out_bit);
                nout++;
            end
        end
        @(negedge clock);
        in_valid  = 1'b0;
        out_ready = 1'b1;

        checks++;
        if (nout != 14 || idx != 12) begin
            errors++;
            $display("FAIL stall_count: got %0d outputs / %0d inputs, expected 14 / 12", nout, idx);
        end
        for (int i = 0; i < nout && i < 14; i++) begin
            checks++;
            if (got[i] !== exp_stream[13-i]) begin
                errors++;
                $display("FAIL stall_bit%0d: got %b, expected %b", i, got[i], exp_stream[13-i]);
            end
        end
        repeat (2) @(negedge clock);
        #1;
        checks++;
        if (out_valid !== 1'b0 || bs_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_idle: got out_valid=%b bs_ready=%b, expected 0 1", out_valid, bs_ready);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_bit_stuffer
`default_nettype wire
